// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: opcode values,
// instruction field geometry and FSM state encoding.
package fetch_unit_pkg;

  // Opcode values carried in IR[DW-1:DW-4]
  localparam logic [3:0] OP_NOOP   = 4'd0;
  localparam logic [3:0] OP_LOD    = 4'd1;
  localparam logic [3:0] OP_STR    = 4'd2;
  localparam logic [3:0] OP_BRA    = 4'd4;
  localparam logic [3:0] OP_BRR    = 4'd5;
  localparam logic [3:0] OP_BNE    = 4'd6;
  localparam logic [3:0] OP_ALU_OP = 4'd8;
  localparam logic [3:0] OP_HLT    = 4'd15;

  // Addressing-mode value carried in IR[DW-5:DW-8]
  localparam logic [3:0] AM_IMM    = 4'd8;

  // Field geometry, counted down from the instruction MSB
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned MM_W     = 4;
  localparam int unsigned OPC_TOP  = 0;      // OPCODE starts at bit DW-1-OPC_TOP
  localparam int unsigned MM_TOP   = OPC_W;  // MM starts at bit DW-1-MM_TOP

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_REQ   = 2'd1,
    ST_IDLE  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Next program counter selection: sequential, absolute or PC-relative.
// All arithmetic wraps modulo 2^AW.
module next_pc_calc #(
  parameter int unsigned AW = 16
) (
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] br_field,
  input  logic          pc_sel,
  input  logic          br_sel,
  output logic [AW-1:0] next_pc
);

  // Offset field is already AW wide, so its sign extension to AW is identity
  logic [AW-1:0] rel_offset;
  assign rel_offset = br_field;

  // Select the next fetch address
  always_comb begin
    next_pc = pc + {{(AW-1){1'b0}}, 1'b1};
    if (pc_sel) begin
      if (br_sel) next_pc = pc + rel_offset;
      else        next_pc = br_field;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, runs the REQ/ACK fetch handshake
// and applies the control unit's PC update requests.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PC_WRITE,
  input  logic          PC_SEL,
  input  logic          BR_SEL,
  input  logic          PC_RST,
  input  logic          IMEM_ACK,
  input  logic [DW-1:0] IMEM_RDATA,
  output logic          IMEM_REQ,
  output logic [AW-1:0] IMEM_ADDR,
  output logic [AW-1:0] PC,
  output logic [DW-1:0] IR,
  output logic [3:0]    OPCODE,
  output logic [3:0]    MM,
  output logic          IR_VALID,
  output logic          BUSY,
  output logic          OVERRUN
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic          req_q, req_d;
  logic          overrun_q, overrun_d;
  logic          discard_q, discard_d;
  logic [AW-1:0] hold_q, hold_d;   // address of the in-flight request being discarded
  logic [AW-1:0] next_pc;
  logic          busy;

  next_pc_calc #(.AW(AW)) u_next_pc_calc (
    .pc       (pc_q),
    .br_field (ir_q[AW-1:0]),
    .pc_sel   (PC_SEL),
    .br_sel   (BR_SEL),
    .next_pc  (next_pc)
  );

  assign busy = (state_q != ST_IDLE);

  // Next-state logic for the fetch FSM and its datapath registers
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    req_d      = req_q;
    overrun_d  = overrun_q;
    discard_d  = discard_q;
    hold_d     = hold_q;
    if (PC_RST) begin
      pc_d       = RESET_PC;
      ir_d       = '0;
      ir_valid_d = 1'b0;
      overrun_d  = 1'b0;
      req_d      = 1'b1;
      state_d    = ST_REQ;
      // An outstanding request cannot be withdrawn: keep its address on the
      // bus and drop its data when it arrives. A coincident ACK ends it now.
      if (state_q == ST_REQ && !IMEM_ACK) begin
        discard_d = 1'b1;
        if (!discard_q) hold_d = pc_q;
      end else begin
        discard_d = 1'b0;
      end
    end else begin
      if (PC_WRITE && busy) overrun_d = 1'b1;
      unique case (state_q)
        ST_START: begin
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
        ST_REQ: begin
          if (IMEM_ACK) begin
            if (discard_q) begin
              discard_d = 1'b0;
            end else begin
              ir_d       = IMEM_RDATA;
              ir_valid_d = 1'b1;
              req_d      = 1'b0;
              state_d    = ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          if (PC_WRITE) begin
            pc_d       = next_pc;
            ir_valid_d = 1'b0;
            req_d      = 1'b1;
            state_d    = ST_REQ;
          end
        end
        default: begin
          req_d   = 1'b0;
          state_d = ST_START;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_START;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      req_q      <= 1'b0;
      overrun_q  <= 1'b0;
      discard_q  <= 1'b0;
      hold_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      req_q      <= req_d;
      overrun_q  <= overrun_d;
      discard_q  <= discard_d;
      hold_q     <= hold_d;
    end
  end

  assign IMEM_REQ  = req_q;
  assign IMEM_ADDR = discard_q ? hold_q : pc_q;
  assign PC        = pc_q;
  assign IR        = ir_q;
  assign OPCODE    = ir_q[DW-1-OPC_TOP -: OPC_W];
  assign MM        = ir_q[DW-1-MM_TOP -: MM_W];
  assign IR_VALID  = ir_valid_q;
  assign BUSY      = busy;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs driven and outputs sampled on the
// falling clock edge, expected values written out by hand.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, pc_write, pc_sel, br_sel, pc_rst, imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, ir_valid, busy, overrun;
  logic [15:0] imem_addr, pc;
  logic [31:0] ir;
  logic [3:0]  opcode, mm;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  always #5 clk = ~clk;

  fetch_unit #(.AW(16), .DW(32), .RESET_PC(16'h0000)) dut (
    .CLK        (clk),
    .RST        (rst),
    .PC_WRITE   (pc_write),
    .PC_SEL     (pc_sel),
    .BR_SEL     (br_sel),
    .PC_RST     (pc_rst),
    .IMEM_ACK   (imem_ack),
    .IMEM_RDATA (imem_rdata),
    .IMEM_REQ   (imem_req),
    .IMEM_ADDR  (imem_addr),
    .PC         (pc),
    .IR         (ir),
    .OPCODE     (opcode),
    .MM         (mm),
    .IR_VALID   (ir_valid),
    .BUSY       (busy),
    .OVERRUN    (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One-cycle PC_WRITE pulse with the given selects
  task automatic issue(input logic sel, input logic br);
    pc_write = 1'b1; pc_sel = sel; br_sel = br;
    step();
    pc_write = 1'b0;
  endtask

  // Hold off for 'waits' cycles with REQ expected high, then ACK for one cycle
  task automatic do_ack(input logic [31:0] data, input int unsigned waits);
    for (int unsigned i = 0; i < waits; i++) begin
      chk("req_wait", {31'b0, imem_req}, 32'd1);
      step();
    end
    imem_ack = 1'b1; imem_rdata = data;
    step();
    imem_ack = 1'b0; imem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
    pc_rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    step(); step();
    chk("rst_busy",    {31'b0, busy},     32'd1);
    chk("rst_req",     {31'b0, imem_req}, 32'd0);
    chk("rst_pc",      {16'b0, pc},       32'd0);
    chk("rst_ir",      ir,                32'd0);
    chk("rst_valid",   {31'b0, ir_valid}, 32'd0);
    chk("rst_overrun", {31'b0, overrun},  32'd0);
    rst = 1'b0;
    step();
    // Automatic first fetch at address 0, two wait cycles
    chk("boot_addr", {16'b0, imem_addr}, 32'h0);
    do_ack(32'h8000_0003, 2);
    chk("boot_valid",  {31'b0, ir_valid}, 32'd1);
    chk("boot_opcode", {28'b0, opcode},   32'd8);
    chk("boot_mm",     {28'b0, mm},       32'd0);
    chk("boot_req",    {31'b0, imem_req}, 32'd0);
    chk("boot_busy",   {31'b0, busy},     32'd0);

    // Absolute branch to 3, then to 5
    issue(1'b1, 1'b0);
    chk("abs3_addr", {16'b0, imem_addr}, 32'h3);
    do_ack(32'h4000_0005, 0);
    issue(1'b1, 1'b0);
    chk("abs5_addr", {16'b0, imem_addr}, 32'h5);
    do_ack(32'h0000_0000, 0);

    // Sequential from 5; IR keeps old value while the fetch is outstanding
    issue(1'b0, 1'b0);
    chk("seq6_addr",  {16'b0, imem_addr}, 32'h6);
    chk("seq6_valid", {31'b0, ir_valid},  32'd0);
    step();
    chk("seq6_valid_w", {31'b0, ir_valid}, 32'd0);
    chk("seq6_ir_old",  ir,                32'h0);
    do_ack(32'h4000_FFFF, 0);
    chk("seq6_ir", ir, 32'h4000_FFFF);

    // Jump to FFFF, then sequential wraps to 0
    issue(1'b1, 1'b0);
    chk("absffff_addr", {16'b0, imem_addr}, 32'hFFFF);
    do_ack(32'h4000_0040, 0);
    issue(1'b0, 1'b0);
    chk("wrap_addr", {16'b0, imem_addr}, 32'h0);
    do_ack(32'h4000_0040, 0);

    // Absolute branch to 0x0040
    issue(1'b1, 1'b0);
    chk("abs40_addr", {16'b0, imem_addr}, 32'h40);
    do_ack(32'h4000_0010, 0);
    issue(1'b1, 1'b0);
    chk("abs10_addr", {16'b0, imem_addr}, 32'h10);
    do_ack(32'h5A00_FFFC, 0);
    chk("brr_opcode", {28'b0, opcode}, 32'd5);
    chk("brr_mm",     {28'b0, mm},     32'hA);

    // Relative branch 0x10 + (-4) = 0x0C
    issue(1'b1, 1'b1);
    chk("relneg_addr", {16'b0, imem_addr}, 32'hC);
    do_ack(32'h4000_0010, 0);
    issue(1'b1, 1'b0);
    do_ack(32'h5000_0005, 0);
    // Relative branch 0x10 + 5 = 0x15
    issue(1'b1, 1'b1);
    chk("relpos_addr", {16'b0, imem_addr}, 32'h15);
    do_ack(32'h0000_0000, 0);

    // PC_RST while a fetch at 0x16 is outstanding
    issue(1'b0, 1'b0);
    chk("pre_rst_addr", {16'b0, imem_addr}, 32'h16);
    pc_rst = 1'b1;
    step();
    pc_rst = 1'b0;
    chk("disc_req",  {31'b0, imem_req}, 32'd1);
    chk("disc_pc",   {16'b0, pc},       32'h0);
    chk("disc_addr", {16'b0, imem_addr}, 32'h16);
    do_ack(32'hDEAD_BEEF, 2);
    chk("disc_req2",  {31'b0, imem_req}, 32'd1);
    chk("disc_ir",    ir,                32'h0);
    chk("disc_valid", {31'b0, ir_valid}, 32'd0);
    chk("disc_addr2", {16'b0, imem_addr}, 32'h0);
    do_ack(32'h8000_0001, 0);
    chk("refetch_ir",    ir,                32'h8000_0001);
    chk("refetch_valid", {31'b0, ir_valid}, 32'd1);
    chk("refetch_pc",    {16'b0, pc},       32'h0);

    // PC_RST coincident with ACK: the ACK data is dropped
    issue(1'b0, 1'b0);
    pc_rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    step();
    pc_rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    chk("rstack_req",   {31'b0, imem_req}, 32'd1);
    chk("rstack_addr",  {16'b0, imem_addr}, 32'h0);
    chk("rstack_ir",    ir,                32'h0);
    chk("rstack_valid", {31'b0, ir_valid}, 32'd0);
    do_ack(32'h4000_0007, 0);
    chk("rstack_ir2", ir, 32'h4000_0007);

    // PC_WRITE while busy sets OVERRUN and leaves PC alone
    issue(1'b0, 1'b0);
    issue(1'b0, 1'b0);
    chk("ovr_flag", {31'b0, overrun}, 32'd1);
    chk("ovr_pc",   {16'b0, pc},      32'h1);
    do_ack(32'h0000_0000, 0);
    chk("ovr_sticky", {31'b0, overrun}, 32'd1);
    pc_rst = 1'b1;
    step();
    pc_rst = 1'b0;
    chk("ovr_clear", {31'b0, overrun},  32'd0);
    chk("prst_pc",   {16'b0, pc},       32'h0);
    chk("prst_req",  {31'b0, imem_req}, 32'd1);

    // Hard reset in the middle of a request
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_req",  {31'b0, imem_req}, 32'd0);
    chk("mid_rst_pc",   {16'b0, pc},       32'h0);
    chk("mid_rst_busy", {31'b0, busy},     32'd1);
    step();
    chk("mid_rst_refetch", {31'b0, imem_req}, 32'd1);
    do_ack(32'h8000_0003, 0);
    chk("final_opcode", {28'b0, opcode}, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
